// File: rtl/adder_pipelined.sv
// adder_pipelined: N-bit two's-complement adder split into STAGES carry-pipelined
// ripple segments of W = N/STAGES bits, with valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input beat handshake (in_ready is combinational)
//   a, b, cin           operands and carry into bit 0
//   sub                 (only with ADDER_PIPELINED_SUB_EN) 1 = compute a - b
//   out_valid,out_ready output beat handshake
//   sum, cout, overflow registered result, carry out of MSB, signed overflow
//
// Optional feature macro: ADDER_PIPELINED_SUB_EN adds the sub input.
module adder_pipelined #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef ADDER_PIPELINED_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned W = N / STAGES;

  // Configuration sanity check at elaboration.
  if ((N % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipelined: N must be a multiple of STAGES");
  end

  // Per-stage registers: operands travel whole (skew), the partial sum collects
  // one finished slice per stage (deskew), carry and valid ride alongside.
  logic [STAGES-1:0]        v_q, v_d;
  logic [STAGES-1:0]        c_q, c_d;
  logic [STAGES-1:0][N-1:0] a_q, a_d;
  logic [STAGES-1:0][N-1:0] b_q, b_d;
  logic [STAGES-1:0][N-1:0] s_q, s_d;
  logic                     ovf_q, ovf_d;

  logic         adv_c;
  logic [N-1:0] b_eff_c;
  logic         cin_eff_c;

  // Global advance: the whole pipe moves unless a result is stuck at the output.
  assign adv_c    = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv_c;

  // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef ADDER_PIPELINED_SUB_EN
  assign b_eff_c   = sub ? ~b : b;
  assign cin_eff_c = sub ? 1'b1 : cin;
`else
  assign b_eff_c   = b;
  assign cin_eff_c = cin;
`endif

  // Next-state for every stage: add one W-bit slice with the incoming carry.
  always_comb begin
    logic [N-1:0] sa, sb, ss;
    logic         sc;
    logic [W:0]   acc;
    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    sa    = '0;
    sb    = '0;
    ss    = '0;
    sc    = 1'b0;
    acc   = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (k == 0) begin
        sa     = a;
        sb     = b_eff_c;
        ss     = '0;
        sc     = cin_eff_c;
        v_d[k] = in_valid;
      end else begin
        sa     = a_q[k-1];
        sb     = b_q[k-1];
        ss     = s_q[k-1];
        sc     = c_q[k-1];
        v_d[k] = v_q[k-1];
      end
      acc = {1'b0, sa[k*W +: W]} + {1'b0, sb[k*W +: W]} + {{W{1'b0}}, sc};
      a_d[k]            = sa;
      b_d[k]            = sb;
      s_d[k]            = ss;
      s_d[k][k*W +: W]  = acc[W-1:0];
      c_d[k]            = acc[W];
      // The final stage produces the MSB, so overflow is resolved there.
      if (k == int'(STAGES) - 1) begin
        ovf_d = (sa[N-1] == sb[N-1]) && (acc[W-1] != sa[N-1]);
      end
    end
  end

  // Pipeline registers; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv_c) begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// Self-checking bench for adder_pipelined (N=32, STAGES=4).
module tb_adder_pipelined;

  localparam int unsigned N      = 32;
  localparam int unsigned STAGES = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [N+1:0] v;   // {overflow, cout, sum}
    int           c;   // cycle of the event
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];

  adder_pipelined #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_PIPELINED_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference: plain (N+1)-bit arithmetic, result packed as {overflow, cout, sum}.
  function automatic logic [N+1:0] ref_add(input logic [N-1:0] xa, input logic [N-1:0] xb,
                                           input logic xc, input logic xs);
    logic [N-1:0] bb;
    logic         cc;
    logic [N:0]   full;
    bb   = xs ? ~xb : xb;
    cc   = xs ? 1'b1 : xc;
    full = {1'b0, xa} + {1'b0, bb} + {{N{1'b0}}, cc};
    return {(xa[N-1] == bb[N-1]) && (full[N-1] != xa[N-1]), full};
  endfunction

  // Record accepted beats (as model results) and delivered results, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back('{ref_add(a, b, cin, sub), cyc});
      if (out_valid && out_ready) got_q.push_back('{{overflow, cout, sum}, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc);
    bit took;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    cin      = xc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      took = in_ready;
      tick();
      if (took) break;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (sum !== '0) begin fails++; $display("FAIL reset_sum got %h want 0", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b want 0", cout); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    clear_queues();
  endtask

  task automatic test_latency();
    bit ok;
    clear_queues();
    out_ready = 1'b1;
    send(32'h0000_0001, 32'h0000_0001, 1'b0);
    idle();
    wait_got(1, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL latency_timeout got %0d results want 1", got_q.size());
    end else begin
      tests++;
      if (got_q[0].c - exp_q[0].c !== STAGES) begin
        fails++; $display("FAIL latency_cycles got %0d want %0d", got_q[0].c - exp_q[0].c, STAGES);
      end
      tests++;
      if (got_q[0].v !== {1'b0, 1'b0, 32'h0000_0002}) begin
        fails++; $display("FAIL latency_value got %h want %h", got_q[0].v, {2'b00, 32'h0000_0002});
      end
    end
  endtask

  task automatic test_carry_overflow();
    bit ok;
    logic [N+1:0] want [4];
    want[0] = {1'b0, 1'b1, 32'h0000_0000};
    want[1] = {1'b0, 1'b0, 32'h0100_0000};
    want[2] = {1'b1, 1'b0, 32'h8000_0000};
    want[3] = {1'b1, 1'b1, 32'h0000_0000};
    clear_queues();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    idle();
    wait_got(4, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL carry_timeout got %0d results want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_q[i].v !== want[i]) begin
          fails++; $display("FAIL carry_ovf_%0d got %h want %h", i, got_q[i].v, want[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    idle();
    wait_got(16, ok);
    tests++;
    if (!ok || exp_q.size() != 16) begin
      fails++; $display("FAIL b2b_count got %0d/%0d want 16", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        tests++;
        if (got_q[i].v !== exp_q[i].v) begin
          fails++; $display("FAIL b2b_value_%0d got %h want %h", i, got_q[i].v, exp_q[i].v);
        end
        if (i > 0) begin
          tests++;
          if (got_q[i].c - got_q[i-1].c !== 1) begin
            fails++; $display("FAIL b2b_gap_%0d got %0d want 1", i, got_q[i].c - got_q[i-1].c);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [N+1:0] snap;
    clear_queues();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        @(negedge clk);
        snap = {overflow, cout, sum};
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          tests++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL stall_ready_%0d got ov=%b ir=%b want ov=1 ir=0", i, out_valid, in_ready);
          end
          tests++;
          if ({overflow, cout, sum} !== snap) begin
            fails++; $display("FAIL stall_stable_%0d got %h want %h", i, {overflow, cout, sum}, snap);
          end
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_got(8, ok);
    repeat (8) tick();
    tests++;
    if (!ok || got_q.size() != 8 || exp_q.size() != 8) begin
      fails++; $display("FAIL bp_count got %0d/%0d want 8", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (got_q[i].v !== exp_q[i].v) begin
          fails++; $display("FAIL bp_value_%0d got %h want %h", i, got_q[i].v, exp_q[i].v);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [N-1:0] xa, xb;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    repeat (2) tick();
    clear_queues();
    rst_n = 1'b1;
    repeat (10) tick();
    tests++;
    if (got_q.size() != 0) begin fails++; $display("FAIL midrst_stale got %0d results want 0", got_q.size()); end
    xa = $urandom;
    xb = $urandom;
    send(xa, xb, 1'b1);
    idle();
    wait_got(1, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL midrst_timeout got %0d results want 1", got_q.size());
    end else begin
      tests++;
      if (got_q[0].c - exp_q[0].c !== STAGES) begin
        fails++; $display("FAIL midrst_latency got %0d want %0d", got_q[0].c - exp_q[0].c, STAGES);
      end
      tests++;
      if (got_q[0].v !== ref_add(xa, xb, 1'b1, 1'b0)) begin
        fails++; $display("FAIL midrst_value got %h want %h", got_q[0].v, ref_add(xa, xb, 1'b1, 1'b0));
      end
    end
  endtask

`ifdef ADDER_PIPELINED_SUB_EN
  task automatic test_sub();
    bit ok;
    logic [N+1:0] want [2];
    want[0] = {1'b0, 1'b1, 32'h0000_0002};   // 5 - 3, no borrow
    want[1] = {1'b0, 1'b0, 32'hFFFF_FFFE};   // 3 - 5, borrow
    clear_queues();
    sub = 1'b1;
    send(32'd5, 32'd3, 1'b0);
    send(32'd3, 32'd5, 1'b1);
    sub = 1'b0;
    idle();
    wait_got(2, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL sub_timeout got %0d results want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_q[i].v !== want[i]) begin
          fails++; $display("FAIL sub_value_%0d got %h want %h", i, got_q[i].v, want[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_latency();
    test_carry_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_PIPELINED_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
